// File: rtl/pattern_tx.sv
// pattern_tx: serial frame transmitter.
// Each frame is a fixed preamble (MSB first) followed by a captured payload
// word (MSB first). A load may request up to 15 repeats of the same payload.
// Repeated frames are separated by a single idle gap cycle. A one-cycle done
// pulse marks the end of a transmission.
// All outputs are registers written by the FSM, so every output is a clean
// Moore output.
module pattern_tx #(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [3:0]        load_count,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  // The bit counter must hold both DATA_W-1 and PRE_W-1.
  localparam int MAX_B = (DATA_W > PRE_W) ? DATA_W : PRE_W;
  localparam int CNT_W = (MAX_B > 1) ? $clog2(MAX_B) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_frames;
  logic [DATA_W-1:0] r_data;
  logic              r_out;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_load_ready;

  logic              w_accept;
  logic [CNT_W-1:0]  w_cnt_dec;
  logic              w_pre_nxt;
  logic              w_data_nxt;
  logic [3:0]        w_count;

  // A load is taken only while the ready register is high, i.e. in IDLE.
  assign w_accept   = load_valid & r_load_ready;
  assign w_cnt_dec  = r_cnt - 1'b1;
  // Bit that follows the one currently on the line. Selected by masking
  // rather than variable indexing, so the counter width never has to
  // match the vector width.
  assign w_pre_nxt  = |(PREAMBLE & (PRE_W'(1) << w_cnt_dec));
  assign w_data_nxt = |(r_data & (DATA_W'(1) << w_cnt_dec));
  // A count of zero is treated as a single frame.
  assign w_count    = (load_count == 4'd0) ? 4'd1 : load_count;

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

  // Transmit FSM. The outputs for the next cycle are registered together
  // with the state, so the first preamble bit appears one cycle after the
  // load is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_frames     <= '0;
      r_data       <= '0;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_load_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_out        <= 1'b0;
          r_out_valid  <= 1'b0;
          if (w_accept) begin
            r_data       <= load_data;
            r_frames     <= w_count;
            r_cnt        <= CNT_W'(PRE_W - 1);
            r_state      <= S_PRE;
            r_out        <= PREAMBLE[PRE_W-1];
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end
        S_PRE: begin
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_out   <= r_data[DATA_W-1];
          end else begin
            r_cnt <= w_cnt_dec;
            r_out <= w_pre_nxt;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_frames    <= r_frames - 1'b1;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            if (r_frames > 4'd1) begin
              r_state <= S_GAP;
            end else begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_load_ready <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_dec;
            r_out <= w_data_nxt;
          end
        end
        S_GAP: begin
          r_state     <= S_PRE;
          r_cnt       <= CNT_W'(PRE_W - 1);
          r_out       <= PREAMBLE[PRE_W-1];
          r_out_valid <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload bits per frame.
REQ-002 SHALL have parameter PRE_W, default 3: preamble length in bits.
REQ-003 SHALL have parameter PREAMBLE, default 3'b101: sync pattern, sent MSB first.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load_valid  input  1  load request qualifier.
REQ-007 SHALL have port load_ready  output  1  block can accept a load.
REQ-008 SHALL have port load_data  input  DATA_W  payload word.
REQ-009 SHALL have port load_count  input  4  frames to send; 0 is treated as 1.
REQ-010 SHALL have port out  output  1  serial bit stream.
REQ-011 SHALL have port out_valid  output  1  out carries a preamble or payload bit.
REQ-012 SHALL have port busy  output  1  transmission in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of transmission.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, PRE, DATA and GAP; every output SHALL be registered or decoded from state only.
REQ-015 SHALL drive load_ready=1 only in IDLE.
REQ-016 SHALL accept a load on a rising edge with load_valid=1 and load_ready=1, capturing load_data and the frame count (load_count, or 1 if load_count=0), then enter PRE.
REQ-017 SHALL ignore load_valid, load_data and load_count outside IDLE; captured values SHALL NOT change mid-transmission.
REQ-018 In PRE: SHALL output PREAMBLE[PRE_W-1] down to PREAMBLE[0], one bit per cycle, with out_valid=1, then enter DATA.
REQ-019 In DATA: SHALL output captured data MSB first, one bit per cycle, with out_valid=1, for DATA_W cycles.
REQ-020 After the last data bit, SHALL decrement the remaining-frame count, then enter GAP if frames remain, otherwise IDLE.
REQ-021 In GAP: SHALL hold out=0 and out_valid=0 for exactly one cycle, then re-enter PRE with the same payload.
REQ-022 First preamble bit SHALL appear in the cycle immediately after the accepting edge (latency 1).
REQ-023 Frame length SHALL be PRE_W+DATA_W cycles; N frames SHALL take N*(PRE_W+DATA_W)+(N-1) cycles.
REQ-024 SHALL assert busy=1 in PRE, DATA and GAP, and busy=0 in IDLE.
REQ-025 SHALL pulse done=1 for exactly one cycle: the first IDLE cycle after the final data bit.
REQ-026 load_ready and done SHALL both be 1 in that cycle; a load accepted on that edge SHALL start a new transmission with no extra idle cycle.
REQ-027 SHALL hold out=0 and out_valid=0 in IDLE and in GAP.
REQ-028 Bit and frame counters SHALL be sized to hold DATA_W-1, PRE_W-1 and 15 without wrap-around.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=IDLE, out=0, out_valid=0, busy=0, done=0, load_ready=1, and all counters and captured data to 0.
REQ-030 Reset asserted mid-frame SHALL abort the transmission immediately, with no done pulse and no completion of the current bit.
REQ-031 After reset deasserts, SHALL accept a load on the first rising edge with load_valid=1.

Verification
REQ-032 Single frame: load_data=8'hA5, load_count=1 -> out=1,0,1 then 1,0,1,0,0,1,0,1 (out_valid=1 for 11 cycles), done pulses in cycle 12, busy low in cycle 12.
REQ-033 Repeat: load_data=8'h3C, load_count=3 -> three 11-bit frames separated by single out_valid=0 gap cycles (35 cycles total), one done pulse only.
REQ-034 Count zero: load_count=0, load_data=8'hFF -> exactly one frame, 101 11111111, then done.
REQ-035 Back-to-back: hold load_valid=1 with a new load_data in the done cycle -> next preamble bit starts in the following cycle; load_valid pulses during busy are ignored.
REQ-036 Mid-frame reset: assert reset=0 during DATA bit 4 -> out, out_valid and busy go to 0 without waiting for a clock edge, done stays 0, load_ready=1.
REQ-037 Loopback: feed out into the team's 101 Moore pattern detector -> detection count equals the number of 101 occurrences in the transmitted stream.
